c_ternary_accumulate4: RTL and testbench

Trit-serial, 4-trit balanced-ternary accumulator that consumes the word selected by the Deselect4 stage (s3..s0) and keeps a running sum. It adds or subtracts the incoming word, one trit per cycle, through a valid/ready handshake. It commits the result on completion and reports overflow, with wrap or saturate behaviour. It sits directly downstream of c_Deselect4 and is the first clocked element in the ternary datapath.

---
 rtl/c_ternary_accumulate4.sv | 196 +++++++++++++++++++
 tb/tb_c_ternary_accumulate4.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/c_ternary_accumulate4.sv
// Trit-serial 4-trit balanced-ternary accumulator: adds or subtracts one word per
// handshake, one trit per cycle, and commits the running sum with wrap or saturate.
module c_ternary_accumulate4 #(
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_word_i,
  input  logic       in_sub_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_word_o,
  output logic       out_ovf_o,
  output logic       out_err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [7:0] ACC_ZERO = 8'hFF;
  localparam logic [7:0] ACC_MAX  = 8'hAA;
  localparam logic [7:0] ACC_MIN  = 8'h55;

  // Trit code to value; the illegal 00 code reads as 0.
  function automatic logic signed [2:0] trit_val(input logic [1:0] t);
    case (t)
      2'b01:   trit_val = -3'sd1;
      2'b10:   trit_val = 3'sd1;
      default: trit_val = 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input logic signed [2:0] v);
    case (v)
      -3'sd1:  trit_enc = 2'b01;
      3'sd1:   trit_enc = 2'b10;
      default: trit_enc = 2'b11;
    endcase
  endfunction

  function automatic logic [7:0] word_neg(input logic [7:0] w);
    for (int k = 0; k < 4; k++) begin
      case (w[2*k +: 2])
        2'b01:   word_neg[2*k +: 2] = 2'b10;
        2'b10:   word_neg[2*k +: 2] = 2'b01;
        default: word_neg[2*k +: 2] = w[2*k +: 2];
      endcase
    end
  endfunction

  logic [1:0]        state_q, state_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        shadow_q, shadow_d;
  logic signed [2:0] carry_q, carry_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_err_q, out_err_d;

  logic [1:0]        op_trit_s, acc_trit_s;
  logic              trit_err_s;
  logic signed [2:0] sum_s, digit_s, carry_nx_s;
  logic [7:0]        step_shadow_s, commit_s;

  // One digit step of the serial adder at trit position idx_q.
  always_comb begin
    op_trit_s  = op_q[{idx_q, 1'b0} +: 2];
    acc_trit_s = acc_q[{idx_q, 1'b0} +: 2];
    trit_err_s = (op_trit_s == 2'b00);
    sum_s      = trit_val(acc_trit_s) + trit_val(op_trit_s) + carry_q;
    case (sum_s)
      -3'sd3:  begin digit_s = 3'sd0;  carry_nx_s = -3'sd1; end
      -3'sd2:  begin digit_s = 3'sd1;  carry_nx_s = -3'sd1; end
      -3'sd1:  begin digit_s = -3'sd1; carry_nx_s = 3'sd0;  end
      3'sd1:   begin digit_s = 3'sd1;  carry_nx_s = 3'sd0;  end
      3'sd2:   begin digit_s = -3'sd1; carry_nx_s = 3'sd1;  end
      3'sd3:   begin digit_s = 3'sd0;  carry_nx_s = 3'sd1;  end
      default: begin digit_s = 3'sd0;  carry_nx_s = 3'sd0;  end
    endcase
    for (int k = 0; k < 4; k++) begin
      if (idx_q == 2'(k)) begin
        step_shadow_s[2*k +: 2] = trit_enc(digit_s);
      end else begin
        step_shadow_s[2*k +: 2] = shadow_q[2*k +: 2];
      end
    end
    if (SATURATE && (carry_nx_s != 3'sd0)) begin
      commit_s = (carry_nx_s > 3'sd0) ? ACC_MAX : ACC_MIN;
    end else begin
      commit_s = step_shadow_s;
    end
  end

  // Next-state logic; clear overrides every state and the input handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    shadow_d    = shadow_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    if (clear_i) begin
      state_d     = ST_IDLE;
      acc_d       = ACC_ZERO;
      out_valid_d = 1'b0;
      out_ovf_d   = 1'b0;
      out_err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            op_d     = in_sub_i ? word_neg(in_word_i) : in_word_i;
            shadow_d = acc_q;
            carry_d  = 3'sd0;
            idx_d    = 2'd0;
            err_d    = 1'b0;
            state_d  = ST_ADD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADD: begin
          shadow_d = step_shadow_s;
          carry_d  = carry_nx_s;
          err_d    = err_q | trit_err_s;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d     = ST_DONE;
            acc_d       = commit_s;
            out_ovf_d   = (carry_nx_s != 3'sd0);
            out_err_d   = err_q | trit_err_s;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_ADD;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_ZERO;
      op_q        <= ACC_ZERO;
      shadow_q    <= ACC_ZERO;
      carry_q     <= 3'sd0;
      idx_q       <= 2'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      shadow_q    <= shadow_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  // Held low for the whole reset assertion, then follows the IDLE state.
  assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign out_valid_o = out_valid_q;
  assign out_word_o  = acc_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_c_ternary_accumulate4.sv
// Scoreboard bench for c_ternary_accumulate4: wrap and saturate instances share stimulus,
// directed words with hand-computed results are queued and checked by per-instance monitors.
module tb_c_ternary_accumulate4;

  typedef struct {
    logic [7:0] w;
    logic       ovf;
    logic       err;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_word = 8'hFF;
  logic       in_sub = 1'b0;
  logic       out_ready = 1'b1;
  logic       rdy0, rdy1, ov0, ov1, ovf0, ovf1, err0, err1;
  logic [7:0] w0, w1;
  logic       ov0_d = 1'b0, ov1_d = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  c_ternary_accumulate4 #(.SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_word_i(in_word), .in_sub_i(in_sub), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_word_o(w0), .out_ovf_o(ovf0), .out_err_o(err0)
  );

  c_ternary_accumulate4 #(.SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_word_i(in_word), .in_sub_i(in_sub), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_word_o(w1), .out_ovf_o(ovf1), .out_err_o(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic mon_check(input string tag, input exp_t e, input logic [7:0] w,
                           input logic f, input logic er);
    chk({tag, "_word"}, 32'(w), 32'(e.w));
    chk({tag, "_ovf"}, 32'(f), 32'(e.ovf));
    chk({tag, "_err"}, 32'(er), 32'(e.err));
    chk({tag, "_latency"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor for the wrapping instance: one pop per out_valid rise.
  always @(negedge clk) begin
    if (rst) begin
      ov0_d <= 1'b0;
    end else begin
      if (ov0 && !ov0_d) begin
        if (q0.size() == 0) chk("unexpected_valid_wrap", 32'(ov0), 32'd0);
        else mon_check("wrap", q0.pop_front(), w0, ovf0, err0);
      end
      ov0_d <= ov0;
    end
  end

  // Monitor for the saturating instance.
  always @(negedge clk) begin
    if (rst) begin
      ov1_d <= 1'b0;
    end else begin
      if (ov1 && !ov1_d) begin
        if (q1.size() == 0) chk("unexpected_valid_sat", 32'(ov1), 32'd0);
        else mon_check("sat", q1.pop_front(), w1, ovf1, err1);
      end
      ov1_d <= ov1;
    end
  end

  task automatic send(input logic [7:0] w, input logic sub, input logic [7:0] e0,
                      input logic [7:0] e1, input logic f0, input logic f1, input logic er);
    int n = 0;
    @(negedge clk);
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(rdy0), 32'd1);
    in_word  = w;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q0.push_back('{w: e0, ovf: f0, err: er, cyc: cyc + 4});
    q1.push_back('{w: e1, ovf: f1, err: er, cyc: cyc + 4});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(q0.size() == 0 && q1.size() == 0 && rdy0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(q0.size() == 0 && q1.size() == 0 && rdy0), 32'd1);
  endtask

  task automatic do_clear();
    wait_idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_word", 32'(w0), 32'hFF);
    chk("clear_ovf", 32'(ovf1), 32'd0);
  endtask

  initial begin
    int n;
    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(rdy0), 32'd0);
    chk("rst_word", 32'(w0), 32'hFF);
    chk("rst_valid", 32'(ov0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(rdy0), 32'd1);
    chk("post_rst_ovf_err", 32'({ovf0, err0}), 32'd0);

    // +5 twice, then subtract from zero
    out_ready = 1'b1;
    send(8'hE5, 1'b0, 8'hE5, 8'hE5, 1'b0, 1'b0, 1'b0);
    send(8'hE5, 1'b0, 8'hEE, 8'hEE, 1'b0, 1'b0, 1'b0);
    do_clear();
    send(8'hE5, 1'b1, 8'hDA, 8'hDA, 1'b0, 1'b0, 1'b0);

    // +40 then +1: wrap to -40 versus clamp at +40
    do_clear();
    send(8'hAA, 1'b0, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0);
    send(8'hFE, 1'b0, 8'h55, 8'hAA, 1'b1, 1'b1, 1'b0);

    // Stall in DONE with a competing in_valid that must be ignored
    do_clear();
    out_ready = 1'b0;
    send(8'hE5, 1'b0, 8'hE5, 8'hE5, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!ov0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_word  = 8'hFE;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(ov0), 32'd1);
      chk("stall_word", 32'(w0), 32'hE5);
      chk("stall_ovf", 32'(ovf0), 32'd0);
      chk("stall_in_ready", 32'(rdy0), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(8'hFE, 1'b0, 8'hE7, 8'hE7, 1'b0, 1'b0, 1'b0);

    // Clear at E2 of an add of 8'hAA onto 8'hE5
    do_clear();
    send(8'hE5, 1'b0, 8'hE5, 8'hE5, 1'b0, 1'b0, 1'b0);
    wait_idle();
    in_word  = 8'hAA;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midop_in_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("midop_no_partial", 32'(w0), 32'hE5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("midop_clear_word", 32'(w0), 32'hFF);
    chk("midop_clear_in_ready", 32'(rdy0), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midop_no_valid", 32'(ov0), 32'd0);
    end

    // Illegal trit code, then a legal add clears the error flag
    send(8'hFC, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    send(8'hE5, 1'b0, 8'hE5, 8'hE5, 1'b0, 1'b0, 1'b0);

    wait_idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
